regfile_wb_ctrl: RTL and testbench

Write-back controller for the single write port of the 32x32-bit register file in the RISC-V core. It accepts results from two producers, the ALU and the load unit, each through a valid/ready handshake and a one-entry holding register. It arbitrates round-robin between them and drives the register file's data, address and write-enable inputs from registered outputs. Writes to x0 are accepted but discarded.

---
 rtl/regfile_wb_ctrl.sv | 127 ++++++++++++
 tb/tb_regfile_wb_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: two-source (ALU/load) round-robin arbiter feeding the register file write port.
// Optional forwarding outputs are enabled with the REGFILE_WB_FWD_EN macro.
module regfile_wb_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             alu_valid,
  output logic             alu_ready,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  input  logic             mem_valid,
  output logic             mem_ready,
  input  logic [4:0]       mem_rd,
  input  logic [31:0]      mem_data,
  output logic [31:0]      wb_data,
  output logic [4:0]       wb_addr,
  output logic             wb_we,
  output logic             busy,
  output logic [CNT_W-1:0] conflict_cnt
`ifdef REGFILE_WB_FWD_EN
  ,
  input  logic [4:0]       fwd_addr1,
  input  logic [4:0]       fwd_addr2,
  output logic             fwd_hit1,
  output logic             fwd_hit2,
  output logic [31:0]      fwd_data1,
  output logic [31:0]      fwd_data2
`endif
);

  typedef enum logic {SRC_ALU, SRC_MEM} src_t;

  src_t        lastGrant;
  src_t        grantSrc;
  logic        grantAny;
  logic        grantAlu;
  logic        grantMem;

  logic        aluHoldV;
  logic [4:0]  aluHoldRd;
  logic [31:0] aluHoldData;
  logic        memHoldV;
  logic [4:0]  memHoldRd;
  logic [31:0] memHoldData;

  logic [4:0]  selRd;
  logic [31:0] selData;

  // Under contention the grant alternates away from the previous winner.
  always_comb begin
    grantAny = aluHoldV | memHoldV;
    grantSrc = SRC_ALU;
    if (aluHoldV && memHoldV)
      grantSrc = (lastGrant == SRC_ALU) ? SRC_MEM : SRC_ALU;
    else if (memHoldV)
      grantSrc = SRC_MEM;
    grantAlu = grantAny && (grantSrc == SRC_ALU);
    grantMem = grantAny && (grantSrc == SRC_MEM);
    selRd    = (grantSrc == SRC_MEM) ? memHoldRd   : aluHoldRd;
    selData  = (grantSrc == SRC_MEM) ? memHoldData : aluHoldData;
  end

  assign alu_ready = !aluHoldV || grantAlu;
  assign mem_ready = !memHoldV || grantMem;
  assign busy      = aluHoldV | memHoldV | wb_we;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aluHoldV    <= 1'b0;
      aluHoldRd   <= '0;
      aluHoldData <= '0;
    end else if (alu_valid && alu_ready) begin
      aluHoldV    <= 1'b1;
      aluHoldRd   <= alu_rd;
      aluHoldData <= alu_data;
    end else if (grantAlu) begin
      aluHoldV    <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      memHoldV    <= 1'b0;
      memHoldRd   <= '0;
      memHoldData <= '0;
    end else if (mem_valid && mem_ready) begin
      memHoldV    <= 1'b1;
      memHoldRd   <= mem_rd;
      memHoldData <= mem_data;
    end else if (grantMem) begin
      memHoldV    <= 1'b0;
    end
  end

  // x0 results still take the grant slot but never raise the write enable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_we     <= 1'b0;
      wb_addr   <= '0;
      wb_data   <= '0;
      lastGrant <= SRC_ALU;
    end else if (grantAny) begin
      wb_we     <= (selRd != 5'd0);
      wb_addr   <= selRd;
      wb_data   <= selData;
      lastGrant <= grantSrc;
    end else begin
      wb_we     <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      conflict_cnt <= '0;
    else if (aluHoldV && memHoldV && (conflict_cnt != '1))
      conflict_cnt <= conflict_cnt + CNT_W'(1);
  end

`ifdef REGFILE_WB_FWD_EN
  assign fwd_hit1  = wb_we && (wb_addr == fwd_addr1) && (fwd_addr1 != 5'd0);
  assign fwd_hit2  = wb_we && (wb_addr == fwd_addr2) && (fwd_addr2 != 5'd0);
  assign fwd_data1 = fwd_hit1 ? wb_data : '0;
  assign fwd_data2 = fwd_hit2 ? wb_data : '0;
`endif

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Randomized bench for regfile_wb_ctrl against a cycle-level behavioural model, plus directed scenarios.
module tb_regfile_wb_ctrl;
  localparam int CW   = 3;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic alu_valid = 1'b0, mem_valid = 1'b0;
  logic alu_ready, mem_ready;
  logic [4:0] alu_rd = '0, mem_rd = '0;
  logic [31:0] alu_data = '0, mem_data = '0;
  logic [31:0] wb_data;
  logic [4:0] wb_addr;
  logic wb_we, busy;
  logic [CW-1:0] conflict_cnt;
`ifdef REGFILE_WB_FWD_EN
  logic [4:0] fwd_addr1 = '0, fwd_addr2 = '0;
  logic fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
`endif

  regfile_wb_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wb_data(wb_data), .wb_addr(wb_addr), .wb_we(wb_we), .busy(busy), .conflict_cnt(conflict_cnt)
`ifdef REGFILE_WB_FWD_EN
    , .fwd_addr1(fwd_addr1), .fwd_addr2(fwd_addr2), .fwd_hit1(fwd_hit1), .fwd_hit2(fwd_hit2),
    .fwd_data1(fwd_data1), .fwd_data2(fwd_data2)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: index 0 = ALU, 1 = MEM.
  bit        hv[2];
  bit [4:0]  hrd[2];
  bit [31:0] hd[2];
  int        mLast;
  bit        mWe;
  bit [4:0]  mAddr;
  bit [31:0] mData;
  int        mCnt;

  function automatic int pickGrant();
    if (hv[0] && hv[1]) return 1 - mLast;
    if (hv[0]) return 0;
    if (hv[1]) return 1;
    return -1;
  endfunction

  function automatic bit readyOf(int s);
    return !hv[s] || (pickGrant() == s);
  endfunction

  task automatic modelReset();
    for (int s = 0; s < 2; s++) begin hv[s] = 0; hrd[s] = 0; hd[s] = 0; end
    mLast = 0; mWe = 0; mAddr = 0; mData = 0; mCnt = 0;
  endtask

  task automatic modelEdge();
    int g;
    bit rdy[2];
    bit vin[2];
    g = pickGrant();
    rdy[0] = readyOf(0); rdy[1] = readyOf(1);
    vin[0] = alu_valid; vin[1] = mem_valid;
    if (hv[0] && hv[1] && mCnt < CMAX) mCnt++;
    if (g >= 0) begin
      mAddr = hrd[g]; mData = hd[g]; mWe = (hrd[g] != 0); mLast = g;
    end else mWe = 0;
    for (int s = 0; s < 2; s++) begin
      if (vin[s] && rdy[s]) begin
        hv[s] = 1;
        hrd[s] = (s == 0) ? alu_rd : mem_rd;
        hd[s]  = (s == 0) ? alu_data : mem_data;
      end else if (g == s) hv[s] = 0;
    end
  endtask

  task automatic checkOutputs();
    checkVal("wb_we", wb_we, mWe);
    checkVal("wb_addr", wb_addr, mAddr);
    checkVal("wb_data", wb_data, mData);
    checkVal("busy", busy, hv[0] | hv[1] | mWe);
    checkVal("conflict_cnt", conflict_cnt, mCnt);
`ifdef REGFILE_WB_FWD_EN
    checkVal("fwd_hit1", fwd_hit1, mWe && mAddr == fwd_addr1 && fwd_addr1 != 0);
    checkVal("fwd_hit2", fwd_hit2, mWe && mAddr == fwd_addr2 && fwd_addr2 != 0);
    checkVal("fwd_data1", fwd_data1, (mWe && mAddr == fwd_addr1 && fwd_addr1 != 0) ? mData : 0);
    checkVal("fwd_data2", fwd_data2, (mWe && mAddr == fwd_addr2 && fwd_addr2 != 0) ? mData : 0);
`endif
  endtask

  // Called at a negedge: drive inputs, check readies, clock once, check outputs at the next negedge.
  task automatic step(input bit av, input bit [4:0] ard, input bit [31:0] ad,
                      input bit mv, input bit [4:0] mrd, input bit [31:0] md);
    alu_valid = av; alu_rd = ard; alu_data = ad;
    mem_valid = mv; mem_rd = mrd; mem_data = md;
    #1;
    checkVal("alu_ready", alu_ready, readyOf(0));
    checkVal("mem_ready", mem_ready, readyOf(1));
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    alu_valid = 0; mem_valid = 0;
    checkOutputs();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic doReset();
    rst = 1;
    @(negedge clk);
    modelReset();
    rst = 0;
    checkVal("rst_we", wb_we, 0);
    checkVal("rst_busy", busy, 0);
    checkVal("rst_cnt", conflict_cnt, 0);
    checkVal("rst_addr", wb_addr, 0);
    checkVal("rst_data", wb_data, 0);
  endtask

  initial begin
    modelReset();
    @(negedge clk);
    doReset();

    // ALU-only write
    step(1, 5, 32'hDEADBEEF, 0, 0, 0);
    checkVal("t1_we_n", wb_we, 0);
    idle();
    checkVal("t1_we", wb_we, 1);
    checkVal("t1_addr", wb_addr, 5);
    checkVal("t1_data", wb_data, 32'hDEADBEEF);
    idle();
    checkVal("t1_we_off", wb_we, 0);

    // Simultaneous arrival: first conflict after reset goes to MEM
    doReset();
    step(1, 1, 32'h11, 1, 2, 32'h22);
    checkVal("t2_mem_rdy", mem_ready, 1);
    checkVal("t2_alu_rdy", alu_ready, 0);
    idle();
    checkVal("t2_addr0", wb_addr, 2);
    checkVal("t2_data0", wb_data, 32'h22);
    checkVal("t2_cnt", conflict_cnt, 1);
    idle();
    checkVal("t2_addr1", wb_addr, 1);
    checkVal("t2_data1", wb_data, 32'h11);
    checkVal("t2_we1", wb_we, 1);
    idle();

    // Back-to-back ALU streaming
    for (int unsigned k = 1; k <= 4; k++) begin
      step(1, 5'(k), 32'h100 + k, 0, 0, 0);
      checkVal("t3_ready", alu_ready, 1);
      if (k > 1) begin
        checkVal("t3_we", wb_we, 1);
        checkVal("t3_addr", wb_addr, k - 1);
      end
    end
    idle();
    checkVal("t3_last", wb_addr, 4);
    checkVal("t3_we_last", wb_we, 1);
    idle();

    // x0 discard
    step(0, 0, 0, 1, 0, 32'hFFFFFFFF);
    checkVal("t4_busy", busy, 1);
    idle();
    checkVal("t4_we", wb_we, 0);
    step(1, 3, 32'h33, 0, 0, 0);
    idle();
    checkVal("t4_alu_we", wb_we, 1);
    checkVal("t4_alu_addr", wb_addr, 3);
    idle();

    // Saturation of the conflict counter
    for (int unsigned k = 0; k < 12; k++)
      step(1, 5'(k + 1), k, 1, 5'(k + 10), k + 32'h1000);
    checkVal("t5_sat", conflict_cnt, CMAX);
    repeat (3) idle();

    // Asynchronous reset mid-flight
    step(1, 8, 32'h88, 1, 9, 32'h99);
    #2 rst = 1;
    #1;
    checkVal("t6_we", wb_we, 0);
    checkVal("t6_busy", busy, 0);
    checkVal("t6_cnt", conflict_cnt, 0);
    @(negedge clk);
    rst = 0;
    modelReset();
    repeat (3) begin
      idle();
      checkVal("t6_nowrite", wb_we, 0);
    end

`ifdef REGFILE_WB_FWD_EN
    step(1, 7, 32'h1234, 0, 0, 0);
    idle();
    fwd_addr1 = 7; fwd_addr2 = 0;
    #1;
    checkVal("t7_hit1", fwd_hit1, 1);
    checkVal("t7_data1", fwd_data1, 32'h1234);
    checkVal("t7_hit2", fwd_hit2, 0);
`endif

    // Randomized traffic
    for (int unsigned i = 0; i < 400; i++) begin
`ifdef REGFILE_WB_FWD_EN
      fwd_addr1 = 5'($urandom_range(0, 31));
      fwd_addr2 = 5'($urandom_range(0, 31));
`endif
      step(($urandom_range(0, 99) < 60), 5'($urandom_range(0, 31)), $urandom,
           ($urandom_range(0, 99) < 50), 5'($urandom_range(0, 31)), $urandom);
    end
    repeat (4) idle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
